pc_unit_rs: RTL and testbench
=============================

Name: pc_unit_rs

Overview:
- Parametrised program-counter unit for the simple single-bus RISC-V CPU; successor to the basic bus-loaded PC.
- Keeps the load-from-bus / drive-to-bus behaviour, and adds:
  - auto-increment by a configurable step
  - PC-relative add from the bus
  - call/return via an internal return-address stack (RAS)
  - sticky error reporting
- Sits on the shared tri-state data bus and is controlled by the control-unit strobes.

Parameters:
- w, 32, PC and bus width in bits.
- STEP, 4, increment applied by PCinc and used for the return address.
- RESET_VEC, 0, PC value after reset (must already be aligned).
- ALIGN_BITS, 2, number of LSBs forced to 0 on every PC write.
- RAS_DEPTH, 4, return-address stack entries (>=2, power of two).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- bus  inout  w  shared tri-state data bus.
- PCin  in  1  load PC from bus.
- PCout  in  1  drive PC onto bus.
- PCinc  in  1  PC <= PC + STEP.
- PCrel  in  1  PC <= PC + signed(bus).
- call  in  1  qualifies PCin/PCrel: push return address (PC+STEP).
- ret  in  1  PC <= top of RAS; pop.
- pc  out  w  current PC (registered, for debug/IMEM).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VEC; RAS count=0; ras_empty=1; ras_full=0; err=0.
  - rst overrides all strobes in the same cycle; RAS contents don't-care.
- Bus drive:
  - bus = pc while PCout=1 and no write strobe (PCin/PCrel) is active; otherwise high-Z.
  - Combinational; valid in the same cycle PCout is asserted.
- PC update priority, one action per posedge: rst > PCin > PCrel > ret > PCinc > hold.
  - PCin: pc <= bus with low ALIGN_BITS cleared.
  - PCrel: pc <= (pc + bus) mod 2^w, low ALIGN_BITS cleared; bus treated as two's complement; wrap-around is silent.
  - ret (non-empty): pc <= RAS top; count decrements.
  - ret (empty): pc unchanged; err set.
  - PCinc: pc <= (pc + STEP) mod 2^w; 0xFFFFFFFC+4 -> 0x00000000, no error.
- call:
  - Effective only together with PCin or PCrel; pushes the old pc+STEP in the same edge the PC changes.
  - Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH; err set.
  - call without PCin/PCrel: ignored; err set.
- Flags: ras_empty/ras_full are registered and reflect count after the edge.
- Latency: every PC change is visible on pc (and via PCout) in the cycle after the strobe edge.
- Illegal combinations (err set; priority still decides the action):
  - PCin or PCrel together with PCout → bus not driven by this unit.
  - ret together with call.
  - ret together with PCin or PCrel: ret is ignored, no pop.
- err clears only on rst.
- X/Z on bus during PCin/PCrel is the caller's fault; no checking required.

Test Plan:
- rst held 2 cycles → pc=0, ras_empty=1, err=0, bus=Z. Then PCout=1 one cycle → bus=0x00000000.
- Drive bus=0x0000000F with PCin=1 one cycle → pc=0x0000000C (aligned); next cycle PCout=1 → bus=0x0000000C.
- From pc=0x100: PCinc ×3 → pc=0x10C. Then bus=0xFFFFFFF0 with PCrel=1 → pc=0x0FC. pc=0xFFFFFFFC with PCinc → pc=0x0, err=0.
- From pc=0x200: call+PCin with bus=0x400 → pc=0x400, RAS top=0x204, ras_empty=0. Then ret → pc=0x204, ras_empty=1, err=0.
- Five nested calls from pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) → ras_full=1, err=1 after the 5th. Four rets → pc sequence 0x54,0x44,0x34,0x24, ras_empty=1. A fifth ret → pc stays 0x24.
- PCin=1 and PCout=1 with bus=0x80 → pc=0x80, unit leaves bus Z, err=1. Then rst mid-sequence → pc=RESET_VEC, err=0, RAS count 0.

Source files
------------

// File: rtl/pc_unit_rs_if.sv
// Control/status bundle between the control unit and the PC unit.
// Ports: strobes pc_in/pc_out/pc_inc/pc_rel/call/ret (master -> slave);
//        pc, ras_empty, ras_full, err, bus_oe (slave -> master).
interface pc_unit_rs_if #(
  parameter int W = 32
);
  logic         pc_in;
  logic         pc_out;
  logic         pc_inc;
  logic         pc_rel;
  logic         call;
  logic         ret;
  logic [W-1:0] pc;
  logic         ras_empty;
  logic         ras_full;
  logic         err;
  logic         bus_oe;    // high while the unit drives the shared bus

  modport master (
    output pc_in, pc_out, pc_inc, pc_rel, call, ret,
    input  pc, ras_empty, ras_full, err, bus_oe
  );

  modport slave (
    input  pc_in, pc_out, pc_inc, pc_rel, call, ret,
    output pc, ras_empty, ras_full, err, bus_oe
  );
endinterface

// File: rtl/pc_unit_rs.sv
// Program-counter unit: load/drive via shared tri-state bus, increment,
// PC-relative add, call/return through a circular return-address stack,
// sticky error flag.
// Ports: i_clk, i_rst (sync, active-high), io_bus (shared tri-state data
//        bus), ctl (pc_unit_rs_if.slave: control strobes in, pc/flags out).
// Latency: one cycle from strobe edge to pc; bus drive is combinational.
module pc_unit_rs #(
  parameter int           w          = 32,
  parameter int           STEP       = 4,
  parameter logic [w-1:0] RESET_VEC  = '0,
  parameter int           ALIGN_BITS = 2,
  parameter int           RAS_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  inout  wire [w-1:0] io_bus,
  pc_unit_rs_if.slave ctl
);

  localparam int               SP_W       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CNT_W      = $clog2(RAS_DEPTH + 1);
  localparam logic [w-1:0]     ALIGN_MASK = ~((w'(1) << ALIGN_BITS) - w'(1));
  localparam logic [w-1:0]     STEP_V     = w'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  logic [w-1:0]     r_pc;
  logic [w-1:0]     r_ras [RAS_DEPTH];
  logic [SP_W-1:0]  r_sp;      // next free slot; wraps, so when full it points at the oldest entry
  logic [CNT_W-1:0] r_cnt;
  logic             r_empty;
  logic             r_full;
  logic             r_err;

  logic             w_wr;
  logic             w_drive;
  logic             w_push;
  logic             w_err_set;
  logic [w-1:0]     w_pc_nxt;
  logic [w-1:0]     w_ret_addr;
  logic [w-1:0]     w_top;
  logic [SP_W-1:0]  w_sp_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Any bus-write strobe means someone else owns the bus this cycle.
  assign w_wr    = ctl.pc_in | ctl.pc_rel;
  assign w_drive = ctl.pc_out & ~w_wr;
  assign io_bus  = w_drive ? r_pc : 'z;

  assign w_ret_addr = r_pc + STEP_V;
  assign w_top      = r_ras[r_sp - SP_W'(1)];

  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_cnt;
    w_push    = 1'b0;
    // Illegal strobe combinations; priority below still picks the action.
    w_err_set = (ctl.pc_out & w_wr)
              | (ctl.call & ~w_wr)
              | (ctl.ret & (ctl.call | w_wr));

    if (ctl.pc_in) begin
      w_pc_nxt = io_bus & ALIGN_MASK;
      w_push   = ctl.call;
    end else if (ctl.pc_rel) begin
      w_pc_nxt = (r_pc + io_bus) & ALIGN_MASK;
      w_push   = ctl.call;
    end else if (ctl.ret) begin
      if (r_cnt != '0) begin
        w_pc_nxt  = w_top;
        w_sp_nxt  = r_sp - SP_W'(1);
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end else begin
        w_err_set = 1'b1;
      end
    end else if (ctl.pc_inc) begin
      w_pc_nxt = r_pc + STEP_V;
    end

    // Push onto a full stack overwrites the oldest slot: pointer advances,
    // count saturates.
    if (w_push) begin
      w_sp_nxt = r_sp + SP_W'(1);
      if (r_cnt == CNT_MAX) begin
        w_err_set = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= RESET_VEC;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_MAX);
      r_err   <= r_err | w_err_set;
    end
  end

  // Stack storage needs no reset; the count decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_ras[r_sp] <= w_ret_addr;
    end
  end

  assign ctl.pc        = r_pc;
  assign ctl.ras_empty = r_empty;
  assign ctl.ras_full  = r_full;
  assign ctl.err       = r_err;
  assign ctl.bus_oe    = w_drive;

endmodule

// File: tb/tb_pc_unit_rs.sv
// Self-checking bench for pc_unit_rs: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_pc_unit_rs;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        tb_bus_en;
  logic [31:0] tb_bus_val;
  wire  [31:0] bus;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_err;

  always #5 clk = ~clk;

  assign bus = tb_bus_en ? tb_bus_val : 'z;

  pc_unit_rs_if #(.W(32)) u_if ();

  pc_unit_rs #(
    .w(32), .STEP(4), .RESET_VEC(RVEC), .ALIGN_BITS(2), .RAS_DEPTH(DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .io_bus(bus),
    .ctl   (u_if.slave)
  );

  task automatic set_idle();
    i_rst        = 1'b0;
    u_if.pc_in   = 1'b0;
    u_if.pc_out  = 1'b0;
    u_if.pc_inc  = 1'b0;
    u_if.pc_rel  = 1'b0;
    u_if.call    = 1'b0;
    u_if.ret     = 1'b0;
    tb_bus_en    = 1'b0;
    tb_bus_val   = '0;
  endtask

  // Behavioural model of one clock edge.
  task automatic model_update(input logic rst, pin, pout, pinc, prel, pcall, pret,
                              input logic [31:0] bv);
    logic wr;
    if (rst) begin
      m_pc  = RVEC;
      m_ras.delete();
      m_err = 1'b0;
      return;
    end
    wr = pin | prel;
    if (pout && wr) m_err = 1'b1;
    if (pcall && !wr) m_err = 1'b1;
    if (pret && (pcall || wr)) m_err = 1'b1;
    if (wr) begin
      if (pcall) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
      end
      m_pc = (pin ? bv : m_pc + bv) & ~32'h3;
    end else if (pret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_err = 1'b1;
    end else if (pinc) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Apply one cycle of strobes, advance the model, return 1ns after the edge idle.
  task automatic drive(input logic rst, pin, pout, pinc, prel, pcall, pret,
                       input logic [31:0] bv);
    i_rst       = rst;
    u_if.pc_in  = pin;
    u_if.pc_out = pout;
    u_if.pc_inc = pinc;
    u_if.pc_rel = prel;
    u_if.call   = pcall;
    u_if.ret    = pret;
    tb_bus_en   = pin | prel;
    tb_bus_val  = bv;
    @(posedge clk);
    model_update(rst, pin, pout, pinc, prel, pcall, pret, bv);
    #1;
    set_idle();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    n_cmp++; if (u_if.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", u_if.pc, 32'h0); end
    n_cmp++; if (u_if.ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", u_if.ras_empty); end
    n_cmp++; if (u_if.ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", u_if.ras_full); end
    n_cmp++; if (u_if.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", u_if.err); end
    n_cmp++; if (u_if.bus_oe !== 1'b0) begin n_fail++; $display("FAIL reset_bus_z oe got %b want 0", u_if.bus_oe); end
    u_if.pc_out = 1'b1;
    #1;
    n_cmp++; if (bus !== 32'h0) begin n_fail++; $display("FAIL reset_bus_drive got %h want %h", bus, 32'h0); end
    n_cmp++; if (u_if.bus_oe !== 1'b1) begin n_fail++; $display("FAIL reset_bus_oe got %b want 1", u_if.bus_oe); end
    drive(0, 0, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_load();
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0000000F);
    n_cmp++; if (u_if.pc !== 32'h0000000C) begin n_fail++; $display("FAIL load_align got %h want %h", u_if.pc, 32'hC); end
    u_if.pc_out = 1'b1;
    #1;
    n_cmp++; if (bus !== 32'h0000000C) begin n_fail++; $display("FAIL load_bus got %h want %h", bus, 32'hC); end
    drive(0, 0, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_inc_rel();
    drive(0, 1, 0, 0, 0, 0, 0, 32'h100);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0, 0, 0, '0);
    n_cmp++; if (u_if.pc !== 32'h10C) begin n_fail++; $display("FAIL inc3 got %h want %h", u_if.pc, 32'h10C); end
    drive(0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFF0);
    n_cmp++; if (u_if.pc !== 32'h0FC) begin n_fail++; $display("FAIL rel_neg got %h want %h", u_if.pc, 32'hFC); end
    drive(0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
    drive(0, 0, 0, 1, 0, 0, 0, '0);
    n_cmp++; if (u_if.pc !== 32'h0) begin n_fail++; $display("FAIL inc_wrap got %h want %h", u_if.pc, 32'h0); end
    n_cmp++; if (u_if.err !== 1'b0) begin n_fail++; $display("FAIL inc_wrap_err got %b want 0", u_if.err); end
  endtask

  task automatic test_call_ret();
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h200);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h400);
    n_cmp++; if (u_if.pc !== 32'h400) begin n_fail++; $display("FAIL call_pc got %h want %h", u_if.pc, 32'h400); end
    n_cmp++; if (u_if.ras_empty !== 1'b0) begin n_fail++; $display("FAIL call_empty got %b want 0", u_if.ras_empty); end
    drive(0, 0, 0, 0, 0, 0, 1, '0);
    n_cmp++; if (u_if.pc !== 32'h204) begin n_fail++; $display("FAIL ret_pc got %h want %h", u_if.pc, 32'h204); end
    n_cmp++; if (u_if.ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty got %b want 1", u_if.ras_empty); end
    n_cmp++; if (u_if.err !== 1'b0) begin n_fail++; $display("FAIL ret_err got %b want 0", u_if.err); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h10);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 0, 0, 1, 0, 32'((k + 1) * 16));
      if (k == 4) begin
        n_cmp++; if (u_if.ras_full !== 1'b1 || u_if.err !== 1'b0) begin
          n_fail++; $display("FAIL ras_full4 full=%b err=%b want full=1 err=0", u_if.ras_full, u_if.err);
        end
      end
    end
    n_cmp++; if (u_if.ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", u_if.ras_full); end
    n_cmp++; if (u_if.err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", u_if.err); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, '0);
      n_cmp++; if (u_if.pc !== exp_ret[k]) begin n_fail++; $display("FAIL ovf_ret%0d got %h want %h", k, u_if.pc, exp_ret[k]); end
    end
    n_cmp++; if (u_if.ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b want 1", u_if.ras_empty); end
    drive(0, 0, 0, 0, 0, 0, 1, '0);
    n_cmp++; if (u_if.pc !== 32'h24) begin n_fail++; $display("FAIL ret_underflow_pc got %h want %h", u_if.pc, 32'h24); end
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    u_if.pc_in  = 1'b1;
    u_if.pc_out = 1'b1;
    tb_bus_en   = 1'b0;
    #1;
    n_cmp++; if (u_if.bus_oe !== 1'b0) begin n_fail++; $display("FAIL conflict_bus_oe got %b want 0", u_if.bus_oe); end
    drive(0, 1, 1, 0, 0, 0, 0, 32'h80);
    n_cmp++; if (u_if.pc !== 32'h80) begin n_fail++; $display("FAIL conflict_pc got %h want %h", u_if.pc, 32'h80); end
    n_cmp++; if (u_if.err !== 1'b1) begin n_fail++; $display("FAIL conflict_err got %b want 1", u_if.err); end
    drive(0, 1, 0, 0, 0, 1, 0, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 0, '0);
    n_cmp++; if (u_if.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", u_if.err); end
    drive(1, 0, 0, 1, 0, 0, 0, '0);
    n_cmp++; if (u_if.pc !== RVEC || u_if.err !== 1'b0 || u_if.ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset pc=%h err=%b empty=%b want pc=%h err=0 empty=1", u_if.pc, u_if.err, u_if.ras_empty, RVEC);
    end
  endtask

  task automatic test_random();
    logic r, pin, pout, pinc, prel, pcall, pret;
    logic [31:0] bv;
    drive(1, 0, 0, 0, 0, 0, 0, '0);
    for (int c = 0; c < 400; c++) begin
      r     = ($urandom_range(0, 59) == 0);
      pin   = ($urandom_range(0, 5) == 0);
      prel  = ($urandom_range(0, 6) == 0);
      pout  = ($urandom_range(0, 3) == 0);
      pinc  = ($urandom_range(0, 2) == 0);
      pcall = ($urandom_range(0, 3) == 0);
      pret  = ($urandom_range(0, 3) == 0);
      bv    = $urandom();
      if (bv[0]) bv = {{24{bv[31]}}, bv[7:0]};  // bias toward small offsets
      i_rst       = r;
      u_if.pc_in  = pin;
      u_if.pc_out = pout;
      u_if.pc_inc = pinc;
      u_if.pc_rel = prel;
      u_if.call   = pcall;
      u_if.ret    = pret;
      tb_bus_en   = pin | prel;
      tb_bus_val  = bv;
      #1;
      n_cmp++; if (u_if.bus_oe !== (pout & ~(pin | prel))) begin
        n_fail++; $display("FAIL rnd_oe c=%0d got %b want %b", c, u_if.bus_oe, pout & ~(pin | prel));
      end
      if (pout && !(pin || prel)) begin
        n_cmp++; if (bus !== m_pc) begin n_fail++; $display("FAIL rnd_bus c=%0d got %h want %h", c, bus, m_pc); end
      end
      @(posedge clk);
      model_update(r, pin, pout, pinc, prel, pcall, pret, bv);
      #1;
      n_cmp++; if (u_if.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got %h want %h", c, u_if.pc, m_pc); end
      n_cmp++; if (u_if.ras_empty !== (m_ras.size() == 0)) begin
        n_fail++; $display("FAIL rnd_empty c=%0d got %b want %b", c, u_if.ras_empty, m_ras.size() == 0);
      end
      n_cmp++; if (u_if.ras_full !== (m_ras.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_full c=%0d got %b want %b", c, u_if.ras_full, m_ras.size() == DEPTH);
      end
      n_cmp++; if (u_if.err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got %b want %b", c, u_if.err, m_err); end
    end
    set_idle();
  endtask

  initial begin
    m_pc  = RVEC;
    m_err = 1'b0;
    set_idle();
    i_rst = 1'b1;
    test_reset();
    test_load();
    test_inc_rel();
    test_call_ret();
    test_ras_overflow();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
